// File: rtl/rv_sim_pkg.sv
// rtl/rv_sim_pkg.sv - shared state encoding and address-map defaults for the DM result checker
//
// Contents:
//   chk_state_e          checker FSM states
//   DEF_ANSWER_START     first answer word (byte address, word aligned)
//   DEF_DONE_ADDR        halt-flag byte address
//   DEF_DONE_BYTE        halt-flag value
//   DEF_MAX_WORDS        golden ROM depth
//   DEF_TIMEOUT          RUN cycle budget
package rv_sim_pkg;

    typedef enum logic [2:0] {
        RUN,
        LATCH,
        RD,
        CMP,
        FIN,
        TOUT
    } chk_state_e;

    localparam int unsigned DEF_ANSWER_START = 32'h0000_9000;
    localparam int unsigned DEF_DONE_ADDR    = 32'h0000_fffc;
    localparam logic [7:0]  DEF_DONE_BYTE    = 8'hff;
    localparam int unsigned DEF_MAX_WORDS    = 100;
    localparam int unsigned DEF_TIMEOUT      = 50000;

endpackage

// File: rtl/dm_result_checker_if.sv
// rtl/dm_result_checker_if.sv - CPU data-memory snoop/read bundle between the memory system and the checker
//
// Signals:
//   dm_we      [3:0]         CPU DM byte write strobes (snooped)
//   dm_addr    [ADDR_W-1:0]  CPU DM byte address (snooped)
//   dm_wdata   [31:0]        CPU DM write data (snooped)
//   chk_re                   checker DM read enable
//   chk_addr   [ADDR_W-1:0]  checker DM byte address, word aligned
//   chk_rdata  [31:0]        DM read data, one cycle after chk_re
//   cpu_stall                freezes the CPU once the checker owns the DM
// Modports:
//   master     memory-system / CPU side
//   slave      checker side
interface dm_result_checker_if #(
    parameter int ADDR_W = 16
);

    logic [3:0]        dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              chk_re;
    logic [ADDR_W-1:0] chk_addr;
    logic [31:0]       chk_rdata;
    logic              cpu_stall;

    modport master (
        output dm_we,
        output dm_addr,
        output dm_wdata,
        output chk_rdata,
        input  chk_re,
        input  chk_addr,
        input  cpu_stall
    );

    modport slave (
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        input  chk_rdata,
        output chk_re,
        output chk_addr,
        output cpu_stall
    );

endinterface

// File: rtl/dm_result_checker_sat_cycle_counter.sv
// rtl/dm_result_checker_sat_cycle_counter.sv - saturating cycle counter with terminal-count flag
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous reset, active low
//   en       in   count enable
//   clr      in   synchronous clear (priority over en)
//   tc       out  count equals TERMINAL; counting stops there
module sat_cycle_counter #(
    parameter int unsigned TERMINAL = 49999,
    localparam int         W        = $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TERMINAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_result_checker.sv
// rtl/dm_result_checker.sv - end-of-run checker: halt snoop, answer-region scan against golden ROM, timeout
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active low
//   bus        if   dm_result_checker_if.slave (DM snoop, checker read port, cpu_stall)
//   gold_num   in   golden word count, sampled when the halt is latched
//   gold_addr  out  golden ROM word index
//   gold_data  in   golden word, one-cycle read latency
//   mm_valid   out  one-cycle pulse per mismatching word
//   mm_addr    out  DM byte address of the mismatch
//   mm_got     out  DM word read
//   mm_exp     out  golden word expected
//   err_cnt    out  number of mismatches so far
//   done       out  scan finished (sticky)
//   pass       out  done with no mismatches (sticky)
//   timeout    out  RUN cycle budget exhausted without a halt (sticky)
module dm_result_checker
    import rv_sim_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int unsigned ANSWER_START = DEF_ANSWER_START,
    parameter int unsigned DONE_ADDR    = DEF_DONE_ADDR,
    parameter logic [7:0]  DONE_BYTE    = DEF_DONE_BYTE,
    parameter int unsigned MAX_WORDS    = DEF_MAX_WORDS,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    localparam int         GW           = $clog2(MAX_WORDS + 1),
    localparam int         GA           = $clog2(MAX_WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    dm_result_checker_if.slave  bus,
    input  logic [GW-1:0]       gold_num,
    output logic [GA-1:0]       gold_addr,
    input  logic [31:0]         gold_data,
    output logic                mm_valid,
    output logic [ADDR_W-1:0]   mm_addr,
    output logic [31:0]         mm_got,
    output logic [31:0]         mm_exp,
    output logic [GW-1:0]       err_cnt,
    output logic                done,
    output logic                pass,
    output logic                timeout
);

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(ANSWER_START);
    localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(DONE_ADDR);
    localparam int                LANE   = int'(DONE_ADDR % 4);
    localparam logic [GW-1:0]     MAXW   = GW'(MAX_WORDS);

    // The scanned region must never reach the halt flag, otherwise the
    // answer words and the halt write would alias.
    if (ANSWER_START + 4 * (MAX_WORDS - 1) >= DONE_ADDR) begin : g_bad_map
        $error("answer region overlaps the halt flag address");
    end

    chk_state_e    state;
    logic [GW-1:0] idx;
    logic [GW-1:0] n_words;
    logic [GW-1:0] n_clamp;
    logic [GW-1:0] idx_inc;
    logic [GW-1:0] err_inc;
    logic          halt_hit;
    logic          mismatch;
    logic          tout_tc;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [GW-1:0] i);
        return BASE + ADDR_W'({i, 2'b00});
    endfunction

    // Only the strobe of the byte lane that holds the flag matters; other
    // lanes of the same word may be written freely.
    assign halt_hit = bus.dm_we[LANE]
                   && (bus.dm_addr == HALT_A)
                   && (bus.dm_wdata[8*LANE +: 8] == DONE_BYTE);

    assign n_clamp  = (gold_num > MAXW) ? MAXW : gold_num;
    assign mismatch = (bus.chk_rdata != gold_data);
    assign idx_inc  = idx + 1'b1;
    assign err_inc  = err_cnt + GW'(mismatch);

    sat_cycle_counter #(
        .TERMINAL (TIMEOUT - 1)
    ) u_tout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RUN),
        .clr   (1'b0),
        .tc    (tout_tc)
    );

    // All outputs are registered on entry to the state that owns them, so
    // done appears 2+2n cycles after the cycle carrying the halt write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            idx           <= '0;
            n_words       <= '0;
            bus.cpu_stall <= 1'b0;
            bus.chk_re    <= 1'b0;
            bus.chk_addr  <= '0;
            gold_addr     <= '0;
            mm_valid      <= 1'b0;
            mm_addr       <= '0;
            mm_got        <= '0;
            mm_exp        <= '0;
            err_cnt       <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            bus.chk_re <= 1'b0;
            mm_valid   <= 1'b0;
            case (state)
                RUN: begin
                    // Halt takes priority over a timeout in the same cycle.
                    if (halt_hit) begin
                        state         <= LATCH;
                        bus.cpu_stall <= 1'b1;
                    end else if (tout_tc) begin
                        state         <= TOUT;
                        timeout       <= 1'b1;
                        bus.cpu_stall <= 1'b1;
                    end
                end
                LATCH: begin
                    n_words <= n_clamp;
                    idx     <= '0;
                    if (n_clamp == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        state        <= RD;
                        bus.chk_re   <= 1'b1;
                        bus.chk_addr <= word_addr('0);
                        gold_addr    <= '0;
                    end
                end
                RD: begin
                    state <= CMP;
                end
                CMP: begin
                    // chk_addr still holds the address read in RD.
                    if (mismatch) begin
                        mm_valid <= 1'b1;
                        mm_addr  <= bus.chk_addr;
                        mm_got   <= bus.chk_rdata;
                        mm_exp   <= gold_data;
                    end
                    err_cnt <= err_inc;
                    idx     <= idx_inc;
                    if (idx_inc == n_words) begin
                        state <= FIN;
                        done  <= 1'b1;
                        pass  <= (err_inc == '0);
                    end else begin
                        state        <= RD;
                        bus.chk_re   <= 1'b1;
                        bus.chk_addr <= word_addr(idx_inc);
                        gold_addr    <= GA'(idx_inc);
                    end
                end
                FIN, TOUT: begin
                    state <= state;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_result_checker.sv
// tb/tb_dm_result_checker.sv - self-checking bench for dm_result_checker
module tb_dm_result_checker;

    localparam int ADDR_W = 16;
    localparam int MAXW   = 100;
    localparam int TOUT   = 20;
    localparam int GW     = 7;
    localparam int GA     = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_result_checker_if #(.ADDR_W(ADDR_W)) bus ();

    logic [GW-1:0]     gold_num;
    logic [GA-1:0]     gold_addr;
    logic [31:0]       gold_data;
    logic              mm_valid;
    logic [ADDR_W-1:0] mm_addr;
    logic [31:0]       mm_got;
    logic [31:0]       mm_exp;
    logic [GW-1:0]     err_cnt;
    logic              done;
    logic              pass;
    logic              timeout;

    dm_result_checker #(.TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .gold_num  (gold_num),
        .gold_addr (gold_addr),
        .gold_data (gold_data),
        .mm_valid  (mm_valid),
        .mm_addr   (mm_addr),
        .mm_got    (mm_got),
        .mm_exp    (mm_exp),
        .err_cnt   (err_cnt),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout)
    );

    // Answer region of DM (word k at 0x9000+4k) and golden ROM.
    logic [31:0] ans  [128];
    logic [31:0] gold [128];

    function automatic logic [31:0] dm_read(input logic [15:0] a);
        if (a >= 16'h9000 && a < 16'h9200) return ans[7'((a - 16'h9000) >> 2)];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (bus.chk_re) bus.chk_rdata <= dm_read(bus.chk_addr);
        gold_data <= gold[gold_addr];
    end

    logic [79:0] mm_q [$];
    always @(negedge clk) begin
        if (rst_n && mm_valid) mm_q.push_back({mm_addr, mm_got, mm_exp});
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dm_we    = 4'b0000;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        mm_q.delete();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic snoop_write(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        step(1);
        idle();
    endtask

    // Reference: a scan over min(gnum, MAXW) words reports every word that
    // differs from the golden ROM, in address order, 2+2n cycles after halt.
    task automatic run_scan(input int gnum);
        logic [79:0] expq [$];
        int n;
        n = (gnum > MAXW) ? MAXW : gnum;
        for (int i = 0; i < n; i++) begin
            if (ans[i] !== gold[i]) expq.push_back({16'(32'h9000 + 4 * i), ans[i], gold[i]});
        end
        do_reset();
        gold_num = GW'(gnum);
        step(2);
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        check("stall_after_halt", bus.cpu_stall, 1'b1);
        step(2 * n);
        check("done_not_early", done, 1'b0);
        step(1);
        check("done_on_time", done, 1'b1);
        check("pass", pass, expq.size() == 0);
        check("err_cnt", err_cnt, expq.size());
        check("timeout_clear", timeout, 1'b0);
        step(1);
        check("chk_re_idle", bus.chk_re, 1'b0);
        check("mm_count", mm_q.size(), expq.size());
        for (int i = 0; i < expq.size() && i < mm_q.size(); i++) begin
            check("mm_entry", mm_q[i], expq[i]);
        end
    endtask

    initial begin
        gold_num = '0;
        for (int i = 0; i < 128; i++) begin
            ans[i]  = 32'h0;
            gold[i] = 32'h0;
        end
        do_reset();
        check("reset_outputs",
              {done, pass, timeout, bus.cpu_stall, bus.chk_re, mm_valid, err_cnt,
               mm_addr, mm_got, mm_exp, gold_addr, bus.chk_addr}, '0);

        // Halt with nothing to compare.
        run_scan(0);

        // All four words match.
        for (int i = 0; i < 4; i++) begin
            gold[i] = 32'(i + 1);
            ans[i]  = 32'(i + 1);
        end
        run_scan(4);

        // One corrupted word.
        ans[1] = 32'hdead_beef;
        run_scan(4);
        check("single_mm_addr", mm_addr, 16'h9004);
        check("single_mm_got", mm_got, 32'hdead_beef);
        check("single_mm_exp", mm_exp, 32'h2);

        // A second halt after FIN changes nothing.
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        step(3);
        check("rehalt_done", done, 1'b1);
        check("rehalt_err", err_cnt, 7'd1);
        check("rehalt_no_mm", mm_q.size(), 1);

        // Writes that must not be taken as a halt.
        do_reset();
        gold_num = '0;
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00fe);
        snoop_write(4'b0001, 16'hfff8, 32'h0000_00ff);
        snoop_write(4'b0010, 16'hfffc, 32'h0000_00ff);
        step(1);
        check("false_halt_stall", bus.cpu_stall, 1'b0);
        check("false_halt_done", done, 1'b0);
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        step(1);
        check("real_halt_after_false", done, 1'b1);

        // Timeout with no halt.
        do_reset();
        step(TOUT - 1);
        check("tout_not_early", timeout, 1'b0);
        step(1);
        check("tout_set", timeout, 1'b1);
        check("tout_stall", bus.cpu_stall, 1'b1);
        check("tout_done", {done, pass}, 2'b00);
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        step(3);
        check("tout_ignores_halt", {done, timeout}, 2'b01);

        // Halt in the same cycle as the final count.
        do_reset();
        gold_num = '0;
        step(TOUT - 1);
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        check("coincide_no_tout", timeout, 1'b0);
        step(1);
        check("coincide_done", {done, pass, timeout}, 3'b110);

        // Reset during CMP of word 2, then a full re-run.
        ans[3] = 32'h1234_5678;
        do_reset();
        gold_num = 7'd4;
        step(2);
        snoop_write(4'b0001, 16'hfffc, 32'h0000_00ff);
        step(6);
        rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs",
              {done, pass, timeout, bus.cpu_stall, bus.chk_re, mm_valid, err_cnt,
               mm_addr, mm_got, mm_exp}, '0);
        run_scan(4);

        // gold_num above the ROM depth is clamped.
        for (int i = 0; i < 128; i++) begin
            gold[i] = $urandom;
            ans[i]  = gold[i];
        end
        ans[99]  = ~gold[99];
        ans[100] = ~gold[100];
        run_scan(127);

        // Randomised contents and lengths.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 128; i++) begin
                gold[i] = $urandom;
                ans[i]  = ($urandom_range(0, 3) == 0) ? $urandom : gold[i];
            end
            run_scan($urandom_range(0, 127));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
